// File: rtl/beep_pkg.sv
// Shared types and default timing for beep_sequencer (defaults assume a 100 MHz clk).
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int unsigned DEF_ON_CYCLES   = 10_000_000;  // 100 ms beep
    localparam int unsigned DEF_GAP_CYCLES  = 5_000_000;   // 50 ms silence
    localparam int unsigned DEF_QUEUE_DEPTH = 7;
    localparam int unsigned DEF_TONE_HALF   = 25_000;      // 2 kHz square wave

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator for passive buzzers; compiled only when BEEP_SEQ_TONE_EN is defined.
// Output starts high on restart and toggles every HALF clocks while enabled; 0 when disabled.
`ifdef BEEP_SEQ_TONE_EN
module tone_gen #(
    parameter int unsigned HALF = 25_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tone
);

    localparam int unsigned W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (!en) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (restart) begin
            cnt_d  = W'(HALF - 1);
            tone_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d  = W'(HALF - 1);
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule
`endif

// File: rtl/beep_sequencer.sv
// Turns trigger rising edges into queued, paced buzzer/LED pulses.
// BEEP_SEQ_TONE_EN: drive beep_out as a square wave during ON instead of a steady level.
//
// state | meaning
// IDLE  | no pulse in progress, waiting for a pending request
// ON    | beep_out active, counting ON_CYCLES
// GAP   | forced silence, counting GAP_CYCLES; never shortened by new requests
module beep_sequencer
    import beep_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = DEF_ON_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int unsigned TONE_HALF   = DEF_TONE_HALF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic beep_out,
    output logic busy,
    output logic dropped
);

    localparam int unsigned CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned PEND_W  = $clog2(QUEUE_DEPTH + 1);

    if (ON_CYCLES < 1 || GAP_CYCLES < 1 || QUEUE_DEPTH < 1 || TONE_HALF < 1) begin : g_bad_param
        $error("beep_sequencer: all timing and depth parameters must be >= 1");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                trig_q;
    logic                busy_q, busy_d;
    logic                drop_q, drop_d;
    logic                evt;
    logic                deq;

    assign evt = trigger & ~trig_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deq     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_q != '0) begin
                    state_d = ST_ON;
                    cnt_d   = CNT_W'(ON_CYCLES - 1);
                    deq     = 1'b1;
                end
            end
            ST_ON: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (pend_q != '0) begin
                    state_d = ST_ON;
                    cnt_d   = CNT_W'(ON_CYCLES - 1);
                    deq     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A coincident dequeue frees a slot, so the event is accepted even when full.
    always_comb begin
        pend_d = pend_q;
        drop_d = 1'b0;
        if (evt && !deq) begin
            if (pend_q == PEND_W'(QUEUE_DEPTH)) begin
                drop_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (deq && !evt) begin
            pend_d = pend_q - PEND_W'(1);
        end
        busy_d = (state_d != ST_IDLE) || (pend_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            trig_q  <= 1'b1;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            trig_q  <= trigger;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign busy    = busy_q;
    assign dropped = drop_q;

`ifdef BEEP_SEQ_TONE_EN
    tone_gen #(
        .HALF(TONE_HALF)
    ) u_tone (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_d == ST_ON),
        .restart((state_d == ST_ON) && (state_q != ST_ON)),
        .tone   (beep_out)
    );
`else
    logic beep_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_q <= 1'b0;
        end else begin
            beep_q <= (state_d == ST_ON);
        end
    end

    assign beep_out = beep_q;
`endif

endmodule

// File: doc/beep_sequencer.md
# beep_sequencer

- Turns trigger events into a paced sequence of fixed-length buzzer/LED pulses, one pulse per event, with a bounded queue so back-to-back events (e.g. rapid coin inserts) each produce a distinct, audible beep.
- Sits on the output side of the user I/O path: the debounced or strobe-level `trigger` comes in, and the clean `beep_out` drives the buzzer/LED pin.

## Interface
- `ON_CYCLES`, 10_000_000 — `beep_out` active length per pulse, in clocks (≥1).
- `GAP_CYCLES`, 5_000_000 — forced-low gap after each pulse, in clocks (≥1).
- `QUEUE_DEPTH`, 7 — maximum pending requests (≥1).
- `TONE_HALF`, 25_000 — tone half-period in clocks; used only with the tone feature.
- `clk` input 1 — single clock; all logic on rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `trigger` input 1 — request source; each rising edge is one request.
- `beep_out` output 1 — registered pulse output.
- `busy` output 1 — high while state ≠ IDLE or pending ≠ 0.
- `dropped` output 1 — one-cycle pulse when a request is lost to a full queue.

## Operation
- Edge detect: `trig_q` register; an event occurs when `trigger & ~trig_q`. `trig_q` resets to 1, so a `trigger` held high through reset is not an event.
- Pending counter, width `$clog2(QUEUE_DEPTH+1)`:
  - increments on an event;
  - decrements when the FSM leaves IDLE.
  - Event and decrement in the same cycle: the count is unchanged and the event is accepted, even at full.
  - Event at `QUEUE_DEPTH` with no decrement: the count holds and `dropped` = 1 for that cycle.
- FSM states IDLE, ON, GAP, with a down-counter sized for `max(ON_CYCLES, GAP_CYCLES)`:
  - IDLE: if pending ≠ 0, go to ON, load `ON_CYCLES-1`, decrement pending.
  - ON: count to 0, then go to GAP and load `GAP_CYCLES-1`.
  - GAP: count to 0, then go to ON (with pending decrement) if pending ≠ 0, else go to IDLE.
- GAP always runs in full; a request never shortens the gap.
- `beep_out` = 1 exactly while the state is ON (without the tone feature).
- Reset values: `beep_out`=0, `busy`=0, `dropped`=0, state IDLE, pending 0, counter 0.
- Reset asserted mid-pulse: `beep_out` drops immediately (asynchronously) and queued requests are discarded.

## Timing
- An event sampled at edge N sets pending=1 after N. The FSM enters ON at edge N+1, so `beep_out` is high after N+1 (latency 2 clocks from the sampled rising edge).
- `beep_out` high for exactly `ON_CYCLES` clocks, then low for at least `GAP_CYCLES` clocks.
- Queued pulse period: exactly `ON_CYCLES+GAP_CYCLES`, with no idle cycle between GAP and the next ON.
- `busy` is registered and rises on the same edge that makes pending nonzero.
- `busy` falls on the edge that enters IDLE with pending 0.
- Maximum accepted burst: `QUEUE_DEPTH` events while IDLE, plus 1 for each dequeue that coincides with an event.

## Configuration
- `BEEP_SEQ_TONE_EN` defined:
  - During ON, `beep_out` toggles every `TONE_HALF` clocks, starting high on ON entry (square wave for a passive buzzer).
  - The tone counter restarts on every ON entry.
  - Outside ON, `beep_out` is 0.
- `BEEP_SEQ_TONE_EN` undefined: `beep_out` is a steady level for an active buzzer or LED. `TONE_HALF` is ignored and no tone logic is synthesized.

## Structure
- Shared package `beep_pkg`: state enum typedef (IDLE/ON/GAP) and default timing constants (100 MHz based).
- Natural sub-module: `tone_gen`, a half-period counter plus toggle flop with enable and restart. Instantiate it only under `BEEP_SEQ_TONE_EN`.
- Edge detect, queue and FSM stay in the top module.

## Test plan
Bench parameters: ON=4, GAP=3, DEPTH=2, TONE_HALF=1.
- Single 1-cycle trigger at edge 10 -> `beep_out` high on edges 11–14 and low from 15; `busy` high 10–17 and low at 18.
- Trigger held high for 50 cycles -> exactly one pulse; no repeat.
- Three events 2 cycles apart while IDLE -> first dequeued at once, queue holds 2, no `dropped`. Result: three pulses with period 7.
- Fourth event while pending=2 and not dequeuing -> `dropped` high one cycle; total pulses stay at three.
- `rst_n` low in the middle of ON -> `beep_out`, `busy` and pending go to 0 immediately; after release, no pulse without a new event. `trigger` high at release produces no event.
- With `BEEP_SEQ_TONE_EN`: single event -> `beep_out` reads 1,0,1,0 across the ON window, then 0 through GAP.
